// File: rtl/sha256_msg_padder_if.sv
// -----------------------------------------------------------------------------
// sha256_msg_padder_if
// Bundles the byte-stream input handshake and the padded word-stream output
// handshake of sha256_msg_padder.
//
// Handshake semantics (both channels): a transfer happens on a rising clock
// edge where valid and ready are both high. A producer that has raised valid
// keeps its payload stable until that transfer. Ready may depend
// combinationally on valid.
//
// Signals:
//   in_data_i      message word, big-endian, byte 0 in [31:24]
//   in_bytes_i     valid bytes in in_data_i (left-justified), 0..4 on last word
//   in_last_i      final word of the message
//   in_valid_i     input word valid
//   in_ready_o     padder can accept an input word
//   out_data_o     padded word W0..W15 of the current 512-bit block
//   out_valid_o    output word valid
//   out_ready_i    downstream accepts the output word
//   out_blk_last_o high with W15 of every block
//   out_msg_last_o high with W15 of the final block of a message
//
// Modports: slave = the padder, master = the upstream/downstream environment.
// -----------------------------------------------------------------------------
interface sha256_msg_padder_if;
    logic [31:0] in_data_i;
    logic [2:0]  in_bytes_i;
    logic        in_last_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] out_data_o;
    logic        out_valid_o;
    logic        out_ready_i;
    logic        out_blk_last_o;
    logic        out_msg_last_o;

    modport slave (
        input  in_data_i,
        input  in_bytes_i,
        input  in_last_i,
        input  in_valid_i,
        output in_ready_o,
        output out_data_o,
        output out_valid_o,
        input  out_ready_i,
        output out_blk_last_o,
        output out_msg_last_o
    );

    modport master (
        output in_data_i,
        output in_bytes_i,
        output in_last_i,
        output in_valid_i,
        input  in_ready_o,
        input  out_data_o,
        input  out_valid_o,
        output out_ready_i,
        input  out_blk_last_o,
        input  out_msg_last_o
    );
endinterface

// File: rtl/sha256_msg_padder.sv
// -----------------------------------------------------------------------------
// sha256_msg_padder
// Turns a byte-granular message word stream into SHA-256 padded 512-bit blocks,
// emitted as 16 big-endian 32-bit words per block: message bytes, a 0x80 byte,
// zero fill, then the 64-bit message bit length.
//
// Ports:
//   clk_100mhz   single clock, rising edge
//   rstn_i       synchronous active-low reset
//   bus          sha256_msg_padder_if.slave (input and output handshakes)
//   busy_o       message in progress (bytes counted or not in MSG)
//   dbg_state_o  current FSM state (0=MSG 1=PAD 2=LEN_HI 3=LEN_LO)
//
// The output is a single register stage. A word is loaded into it whenever the
// register is empty or its current word is being taken in the same cycle, so
// an accepted input word appears on out_data_o one cycle later and the
// register holds steady while the downstream stalls.
// -----------------------------------------------------------------------------
module sha256_msg_padder (
    input  logic                      clk_100mhz,
    input  logic                      rstn_i,
    sha256_msg_padder_if.slave        bus,
    output logic                      busy_o,
    output logic [1:0]                dbg_state_o
);

    typedef enum logic [1:0] {
        MSG    = 2'd0,
        PAD    = 2'd1,
        LEN_HI = 2'd2,
        LEN_LO = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;         // block index of the next word loaded
    logic [60:0] cnt_q, cnt_d;         // message length in bytes
    logic        pend_q, pend_d;       // 0x80000000 word still owed after a full last word
    logic [31:0] out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic        blk_last_q, blk_last_d;
    logic        msg_last_q, msg_last_d;

    logic        can_load;
    logic        in_ready;
    logic        load;
    logic        load_msg_last;
    logic [31:0] load_word;
    logic [2:0]  n_eff;
    logic [31:0] last_word;
    logic [63:0] bit_len;

    assign bit_len = {cnt_q, 3'b000};

    // Non-last words always count as four bytes; a last word never counts more.
    always_comb begin
        n_eff = 3'd4;
        if (bus.in_last_i && (bus.in_bytes_i < 3'd4)) begin
            n_eff = bus.in_bytes_i;
        end
    end

    // Short last word: keep bytes 0..n-1, put 0x80 in byte n, zero the rest.
    always_comb begin
        last_word = bus.in_data_i;
        case (n_eff)
            3'd0:    last_word = 32'h8000_0000;
            3'd1:    last_word = {bus.in_data_i[31:24], 24'h80_0000};
            3'd2:    last_word = {bus.in_data_i[31:16], 16'h8000};
            3'd3:    last_word = {bus.in_data_i[31:8], 8'h80};
            default: last_word = bus.in_data_i;
        endcase
    end

    assign can_load = !out_valid_q || bus.out_ready_i;
    assign in_ready = rstn_i && (state_q == MSG) && can_load;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        pend_d        = pend_q;
        out_data_d    = out_data_q;
        out_valid_d   = out_valid_q;
        blk_last_d    = blk_last_q;
        msg_last_d    = msg_last_q;
        load          = 1'b0;
        load_msg_last = 1'b0;
        load_word     = 32'h0;

        case (state_q)
            MSG: begin
                if (in_ready && bus.in_valid_i) begin
                    load  = 1'b1;
                    cnt_d = cnt_q + 61'(n_eff);
                    if (!bus.in_last_i) begin
                        load_word = bus.in_data_i;
                    end else if (n_eff == 3'd4) begin
                        load_word = bus.in_data_i;
                        pend_d    = 1'b1;
                        state_d   = PAD;
                    end else begin
                        load_word = last_word;
                        // 0x80 landed in W13: the length words follow directly.
                        state_d   = (idx_q == 4'd13) ? LEN_HI : PAD;
                    end
                end
            end
            PAD: begin
                if (can_load) begin
                    load      = 1'b1;
                    load_word = pend_q ? 32'h8000_0000 : 32'h0;
                    pend_d    = 1'b0;
                    // Padding never reaches W14 on its own; when the marker
                    // sits in W14/W15 the index wraps and fills a new block.
                    if (idx_q == 4'd13) begin
                        state_d = LEN_HI;
                    end
                end
            end
            LEN_HI: begin
                if (can_load) begin
                    load      = 1'b1;
                    load_word = bit_len[63:32];
                    state_d   = LEN_LO;
                end
            end
            LEN_LO: begin
                if (can_load) begin
                    load          = 1'b1;
                    load_msg_last = 1'b1;
                    load_word     = bit_len[31:0];
                    state_d       = MSG;
                end
            end
            default: begin
                state_d = MSG;
            end
        endcase

        if (load) begin
            out_data_d  = load_word;
            out_valid_d = 1'b1;
            blk_last_d  = (idx_q == 4'd15);
            msg_last_d  = load_msg_last;
            idx_d       = idx_q + 4'd1;
        end else if (can_load) begin
            out_valid_d = 1'b0;
            blk_last_d  = 1'b0;
            msg_last_d  = 1'b0;
        end

        if (load_msg_last) begin
            cnt_d = '0;
            idx_d = '0;
        end
    end

    always_ff @(posedge clk_100mhz) begin
        if (!rstn_i) begin
            state_q     <= MSG;
            idx_q       <= '0;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            blk_last_q  <= 1'b0;
            msg_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            blk_last_q  <= blk_last_d;
            msg_last_q  <= msg_last_d;
        end
    end

    assign bus.in_ready_o     = in_ready;
    assign bus.out_data_o     = out_data_q;
    assign bus.out_valid_o    = out_valid_q;
    assign bus.out_blk_last_o = blk_last_q;
    assign bus.out_msg_last_o = msg_last_q;
    assign busy_o             = (cnt_q != '0) || (state_q != MSG);
    assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_sha256_msg_padder.sv
module tb_sha256_msg_padder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn;
  logic busy;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  sha256_msg_padder_if bus ();

  sha256_msg_padder dut (
    .clk_100mhz (clk),
    .rstn_i     (rstn),
    .bus        (bus.slave),
    .busy_o     (busy),
    .dbg_state_o(dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic [33:0] exp_q[$];   // {blk_last, msg_last, data}
  logic [33:0] got_q[$];
  bit          sb_en = 1'b0;
  bit          rand_ready = 1'b0;

  typedef struct {
    string       name;
    int          n;          // message length in bytes
    logic [7:0]  base;       // byte k of the message = base + k
    int          exp_words;  // words in the padded stream
    int          mark_idx;   // word holding the 0x80 marker
    logic [31:0] mark;       // expected value of that word
    logic [31:0] w_last;     // expected final word (length low)
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model: textbook SHA-256 padding ----------------
  task automatic model_push(input int n, input logic [7:0] base);
    logic [7:0]  b[$];
    logic [63:0] bits;
    int          nw;
    for (int k = 0; k < n; k++) b.push_back(8'(int'(base) + k));
    b.push_back(8'h80);
    while ((b.size() % 64) != 56) b.push_back(8'h00);
    bits = 64'(n) * 64'd8;
    for (int k = 7; k >= 0; k--) b.push_back(bits[k*8 +: 8]);
    nw = b.size() / 4;
    for (int w = 0; w < nw; w++) begin
      exp_q.push_back({(w % 16) == 15, w == nw - 1,
                       b[4*w], b[4*w+1], b[4*w+2], b[4*w+3]});
    end
  endtask

  // ---------------- drivers ----------------
  always @(posedge clk) begin
    #1;
    bus.out_ready_i = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  task automatic send_msg(input int n, input logic [7:0] base, input bit gaps);
    int nw;
    int t;
    int nb;
    int k;
    logic [31:0] d;
    nw = (n == 0) ? 1 : (n + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      for (int j = 0; j < 4; j++) begin
        k = 4 * w + j;
        d[31-8*j -: 8] = (k < n) ? 8'(int'(base) + k) : 8'hA5;
      end
      nb = (w == nw - 1) ? (n - 4 * w) : 4;
      bus.in_data_i  = d;
      bus.in_bytes_i = 3'(nb);
      bus.in_last_i  = (w == nw - 1);
      bus.in_valid_i = 1'b1;
      t = 0;
      @(negedge clk);
      while (!bus.in_ready_o && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (!bus.in_ready_o) begin
        n_checks++;
        n_errors++;
        $display("FAIL in_accept_timeout: got in_ready=0 expected 1 within 200 cycles");
        bus.in_valid_i = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      bus.in_valid_i = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_remaining", 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  // ---------------- scoreboard / monitor ----------------
  bit          prev_stall = 1'b0;
  logic [34:0] prev_out;

  always @(negedge clk) begin
    logic [33:0] got;
    logic [33:0] e;
    if (rstn) begin
      if (prev_stall) begin
        chk("stall_hold", 64'({bus.out_valid_o, bus.out_blk_last_o, bus.out_msg_last_o, bus.out_data_o}),
            64'(prev_out));
      end
      if (dbg_state != 2'd0) begin
        chk("in_ready_outside_msg", 64'(bus.in_ready_o), 64'd0);
      end
      if (bus.out_valid_o && bus.out_ready_i && sb_en) begin
        got = {bus.out_blk_last_o, bus.out_msg_last_o, bus.out_data_o};
        got_q.push_back(got);
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 64'(got), 64'h3_0000_0000_0000);
        end else begin
          e = exp_q.pop_front();
          chk("stream_word", 64'(got), 64'(e));
        end
      end
      prev_stall = bus.out_valid_o && !bus.out_ready_i;
      prev_out   = {bus.out_valid_o, bus.out_blk_last_o, bus.out_msg_last_o, bus.out_data_o};
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- per-case runner ----------------
  task automatic run_case(input int i, input bit gaps);
    int sz;
    @(posedge clk);
    #1;
    got_q.delete();
    model_push(vecs[i].n, vecs[i].base);
    send_msg(vecs[i].n, vecs[i].base, gaps);
    wait_drain();
    sz = got_q.size();
    chk({vecs[i].name, "_words"}, 64'(sz), 64'(vecs[i].exp_words));
    chk({vecs[i].name, "_mark"},
        64'((vecs[i].mark_idx < sz) ? got_q[vecs[i].mark_idx][31:0] : 32'hDEAD_BEEF),
        64'(vecs[i].mark));
    chk({vecs[i].name, "_wlast"},
        64'((sz > 0) ? got_q[sz-1][31:0] : 32'hDEAD_BEEF), 64'(vecs[i].w_last));
    chk({vecs[i].name, "_flags_last"},
        64'((sz > 0) ? got_q[sz-1][33:32] : 2'b00), 64'd3);
    chk({vecs[i].name, "_busy_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic check_reset_values(input string tag, input bit check_ready);
    chk({tag, "_out_valid"},  64'(bus.out_valid_o), 64'd0);
    chk({tag, "_out_data"},   64'(bus.out_data_o), 64'd0);
    chk({tag, "_blk_last"},   64'(bus.out_blk_last_o), 64'd0);
    chk({tag, "_msg_last"},   64'(bus.out_msg_last_o), 64'd0);
    chk({tag, "_busy"},       64'(busy), 64'd0);
    chk({tag, "_state"},      64'(dbg_state), 64'd0);
    if (check_ready) chk({tag, "_in_ready"}, 64'(bus.in_ready_o), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t;
    vecs[0] = '{"A",     1,  8'h41, 16, 0,  32'h4180_0000, 32'h0000_0008};
    vecs[1] = '{"empty", 0,  8'h00, 16, 0,  32'h8000_0000, 32'h0000_0000};
    vecs[2] = '{"abc",   3,  8'h61, 16, 0,  32'h6162_6380, 32'h0000_0018};
    vecs[3] = '{"b55",   55, 8'hCD, 16, 13, 32'h0102_0380, 32'h0000_01B8};
    vecs[4] = '{"b56",   56, 8'h00, 32, 14, 32'h8000_0000, 32'h0000_01C0};
    vecs[5] = '{"b60",   60, 8'h10, 32, 15, 32'h8000_0000, 32'h0000_01E0};
    vecs[6] = '{"b64",   64, 8'h20, 32, 16, 32'h8000_0000, 32'h0000_0200};

    rstn           = 1'b0;
    bus.in_data_i  = '0;
    bus.in_bytes_i = '0;
    bus.in_last_i  = 1'b0;
    bus.in_valid_i = 1'b0;
    bus.out_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset", 1'b1);
    @(posedge clk);
    #1;
    rstn  = 1'b1;
    sb_en = 1'b1;

    // Directed vectors, downstream always ready, no input gaps.
    for (int i = 0; i < 7; i++) run_case(i, 1'b0);

    // Same vectors with random backpressure and input gaps.
    rand_ready = 1'b1;
    for (int i = 0; i < 7; i++) run_case(i, 1'b1);
    for (int i = 2; i < 5; i++) run_case(i, 1'b1);

    // Back-to-back messages: second starts right after the first's length words.
    @(posedge clk);
    #1;
    got_q.delete();
    model_push(3, 8'h61);
    model_push(56, 8'h00);
    send_msg(3, 8'h61, 1'b0);
    send_msg(56, 8'h00, 1'b0);
    wait_drain();
    chk("b2b_words", 64'(got_q.size()), 64'd48);

    // Reset asserted for one cycle while padding an "A" message.
    rand_ready = 1'b0;
    sb_en      = 1'b0;
    @(posedge clk);
    #1;
    send_msg(1, 8'h41, 1'b0);
    t = 0;
    while (dbg_state != 2'd1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("reach_pad", 64'(dbg_state), 64'd1);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    @(negedge clk);
    chk("rst_in_ready_low", 64'(bus.in_ready_o), 64'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    check_reset_values("midpad_reset", 1'b0);
    exp_q.delete();
    got_q.delete();
    sb_en = 1'b1;
    run_case(0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
